// File: rtl/stim_vector_gen_pkg.sv
// Shared types, constants and helpers for the stimulus vector generator.
// Pure declarations: no clocked logic, no latency.
// No flow control here; users apply the helpers under their own handshake.
package stim_pkg;

    typedef enum logic [1:0] {
        STIM_RAND  = 2'd0,
        STIM_COUNT = 2'd1,
        STIM_WALK  = 2'd2,
        STIM_CONST = 2'd3
    } stim_mode_e;

    localparam logic [31:0] LFSR_MASK   = 32'h80200003;
    localparam logic [31:0] SEED_GOLDEN = 32'h9E3779B9;

    // One Galois step: shift right, fold the mask back in when a one falls out.
    function automatic logic [31:0] lfsr_next(input logic [31:0] r);
        logic [31:0] n;
        n = r >> 1;
        if (r[0]) n = n ^ LFSR_MASK;
        return n;
    endfunction

    // Per-channel seed decorrelation; zero would lock the LFSR so it becomes one.
    function automatic logic [31:0] chan_seed(input logic [31:0] seed, input int unsigned c);
        logic [31:0] s;
        s = seed ^ (32'(c) * SEED_GOLDEN);
        if (s == 32'h0) s = 32'h00000001;
        return s;
    endfunction

endpackage

// File: rtl/stim_vector_gen_if.sv
// Handshake bundle between the vector generator and its consumer/controller.
// Wires only, no latency.
// vec_valid/vec_ready carry the backpressure; control inputs are unqualified.
interface stim_vector_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) ();
    logic                       start;
    logic [1:0]                 mode;
    logic [31:0]                seed;
    logic [CNT_W-1:0]           num_vec;
    logic [NUM_CH*DATA_W-1:0]   vec_data;
    logic                       vec_valid;
    logic                       vec_ready;
    logic [CNT_W-1:0]           vec_idx;
    logic                       busy;
    logic                       done;

    modport master (
        input  start, mode, seed, num_vec, vec_ready,
        output vec_data, vec_valid, vec_idx, busy, done
    );

    modport slave (
        output start, mode, seed, num_vec, vec_ready,
        input  vec_data, vec_valid, vec_idx, busy, done
    );
endinterface

// File: rtl/stim_vector_gen_lfsr32.sv
// One 32-bit Galois LFSR channel with synchronous seed load and step enable.
// State updates one cycle after load/step; o_next is combinational lookahead.
// Holds its state whenever neither load nor step is asserted.
module stim_lfsr32
    import stim_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic [31:0] i_seed,
    input  logic        i_step,
    output logic [31:0] o_next
);
    logic [31:0] r_state;

    // Load wins over step so a fresh run always starts from its seed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= 32'h00000001;
        end else if (i_load) begin
            r_state <= i_seed;
        end else if (i_step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_next = lfsr_next(r_state);

endmodule

// File: rtl/stim_vector_gen.sv
// Multi-lane stimulus vector generator: random, counting, walking-one or constant lanes.
// Vector 0 is presented the cycle after an accepted start, then one vector per handshake.
// While vec_valid && !vec_ready the vector, index and LFSRs all hold.
module stim_vector_gen
    import stim_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    stim_vector_gen_if.master    bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]                 r_state;
    logic [CNT_W-1:0]           r_idx;
    logic [CNT_W-1:0]           r_num;
    stim_mode_e                 r_mode;
    logic [DATA_W-1:0]          r_const;
    logic [NUM_CH*DATA_W-1:0]   r_vec_data;
    logic                       r_valid;
    logic                       r_done;

    logic                       w_hs;
    logic                       w_last;
    logic                       w_load;
    logic [NUM_CH*DATA_W-1:0]   w_first_data;
    logic [NUM_CH*DATA_W-1:0]   w_step_data;
    logic [NUM_CH-1:0][31:0]    w_seed;
    logic [NUM_CH-1:0][31:0]    w_lfsr_next;

    // Lane value for a given mode/index; random lanes take the low bits of the LFSR.
    function automatic logic [DATA_W-1:0] lane_val(
        input stim_mode_e        m,
        input logic [CNT_W-1:0]  idx,
        input int                c,
        input logic [31:0]       lfsr,
        input logic [DATA_W-1:0] k
    );
        logic [31:0]       s;
        logic [DATA_W-1:0] one;
        logic [DATA_W-1:0] v;
        s      = 32'(idx) + 32'(c);
        one    = '0;
        one[0] = 1'b1;
        case (m)
            STIM_RAND:  v = lfsr[DATA_W-1:0];
            STIM_COUNT: v = s[DATA_W-1:0];
            STIM_WALK:  v = one << (s % 32'(DATA_W));
            default:    v = k;
        endcase
        return v;
    endfunction

    assign w_hs   = r_valid && bus.vec_ready;
    // Compare against the sampled count so the full counter range never wraps.
    assign w_last = (r_idx == (r_num - CNT_W'(1)));
    assign w_load = (r_state == S_IDLE) && bus.start && (bus.num_vec != '0);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_seed[c] = chan_seed(bus.seed, c);

        stim_lfsr32 u_lfsr (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_load),
            .i_seed (w_seed[c]),
            .i_step (w_hs),
            .o_next (w_lfsr_next[c])
        );

        // Vector 0 comes straight from the seeds; later vectors from the LFSR lookahead.
        assign w_first_data[c*DATA_W +: DATA_W] =
            lane_val(stim_mode_e'(bus.mode), {CNT_W{1'b0}}, c, w_seed[c], bus.seed[DATA_W-1:0]);
        assign w_step_data[c*DATA_W +: DATA_W] =
            lane_val(r_mode, r_idx + CNT_W'(1), c, w_lfsr_next[c], r_const);
    end

    // Run control: sample the job on start, advance on handshake, pulse done after the last one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_num      <= '0;
            r_mode     <= STIM_RAND;
            r_const    <= '0;
            r_vec_data <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.num_vec == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state    <= S_RUN;
                            r_valid    <= 1'b1;
                            r_idx      <= '0;
                            r_num      <= bus.num_vec;
                            r_mode     <= stim_mode_e'(bus.mode);
                            r_const    <= bus.seed[DATA_W-1:0];
                            r_vec_data <= w_first_data;
                        end
                    end
                end
                default: begin
                    if (w_hs) begin
                        if (w_last) begin
                            r_state    <= S_IDLE;
                            r_valid    <= 1'b0;
                            r_done     <= 1'b1;
                            r_idx      <= '0;
                            r_vec_data <= '0;
                        end else begin
                            r_idx      <= r_idx + CNT_W'(1);
                            r_vec_data <= w_step_data;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.vec_data  = r_vec_data;
    assign bus.vec_valid = r_valid;
    assign bus.vec_idx   = r_idx;
    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = r_done;

endmodule

// File: tb/tb_stim_vector_gen.sv
// Scoreboard bench for stim_vector_gen: a 32-bit-lane instance and an 8-bit-lane instance.
// Stimulus pushes hand-computed expected vectors; per-instance monitors pop on handshake.
// Backpressure is exercised by dropping vec_ready mid-run.
module tb_stim_vector_gen;

    typedef struct {
        logic [15:0]  idx;
        logic [127:0] data;
        logic [127:0] mask;
    } exp_t;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;
    int hs32 = 0, hs8 = 0, done32 = 0, done8 = 0;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;

    localparam logic [127:0] M_ALL  = {128{1'b1}};
    localparam logic [127:0] M_L0   = 128'hFFFFFFFF;
    localparam logic [127:0] M_L01  = 128'hFFFFFFFF_FFFFFFFF;

    stim_vector_gen_if #(.NUM_CH(4), .DATA_W(32), .CNT_W(16)) if32 ();
    stim_vector_gen_if #(.NUM_CH(4), .DATA_W(8),  .CNT_W(16)) if8  ();

    stim_vector_gen #(.NUM_CH(4), .DATA_W(32), .CNT_W(16)) u_dut32 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if32)
    );

    stim_vector_gen #(.NUM_CH(4), .DATA_W(8), .CNT_W(16)) u_dut8 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push32(input int idx, input logic [127:0] d, input logic [127:0] m);
        exp_t e;
        e.idx = 16'(idx); e.data = d; e.mask = m;
        q32.push_back(e);
    endtask

    task automatic push8(input int idx, input logic [31:0] d);
        exp_t e;
        e.idx = 16'(idx); e.data = {96'h0, d}; e.mask = M_ALL;
        q8.push_back(e);
    endtask

    // Returns #1 after the edge that sampled start.
    task automatic start32(input logic [1:0] m, input logic [31:0] sd, input int n);
        if32.mode = m; if32.seed = sd; if32.num_vec = 16'(n); if32.start = 1'b1;
        cyc(1);
        if32.start = 1'b0;
    endtask

    task automatic wait_done32(input int maxc);
        int k;
        k = 0;
        while (!if32.done && k < maxc) begin
            cyc(1);
            k++;
        end
        chk("done32_within_budget", 128'(if32.done), 128'(1));
    endtask

    task automatic wait_done8(input int maxc);
        int k;
        k = 0;
        while (!if8.done && k < maxc) begin
            cyc(1);
            k++;
        end
        chk("done8_within_budget", 128'(if8.done), 128'(1));
    endtask

    task automatic chk_idle32(input string name);
        chk({name, "_data"},  if32.vec_data,          128'h0);
        chk({name, "_valid"}, 128'(if32.vec_valid),   128'h0);
        chk({name, "_idx"},   128'(if32.vec_idx),     128'h0);
        chk({name, "_busy"},  128'(if32.busy),        128'h0);
        chk({name, "_done"},  128'(if32.done),        128'h0);
    endtask

    // Monitor for the 32-bit instance: every handshake must match the queue head.
    always @(negedge clk) begin
        if (if32.vec_valid && if32.vec_ready) begin
            hs32++;
            if (q32.size() == 0) begin
                n_checks++;
                $display("FAIL vec32_unexpected: idx %0d data %h, nothing expected", if32.vec_idx, if32.vec_data);
            end else begin
                e32 = q32.pop_front();
                chk("vec32_idx",  128'(if32.vec_idx), 128'(e32.idx));
                chk("vec32_data", if32.vec_data & e32.mask, e32.data & e32.mask);
            end
        end
        if (if32.done) done32++;
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (if8.vec_valid && if8.vec_ready) begin
            hs8++;
            if (q8.size() == 0) begin
                n_checks++;
                $display("FAIL vec8_unexpected: idx %0d data %h, nothing expected", if8.vec_idx, if8.vec_data);
            end else begin
                e8 = q8.pop_front();
                chk("vec8_idx",  128'(if8.vec_idx),  128'(e8.idx));
                chk("vec8_data", 128'(if8.vec_data), e8.data);
            end
        end
        if (if8.done) done8++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int hbase, dbase, k;
        logic [31:0]  d8;
        logic [127:0] d32;

        rst_n = 1'b0;
        if32.start = 1'b0; if32.mode = 2'd0; if32.seed = 32'h0; if32.num_vec = 16'h0; if32.vec_ready = 1'b0;
        if8.start  = 1'b0; if8.mode  = 2'd0; if8.seed  = 32'h0; if8.num_vec  = 16'h0; if8.vec_ready  = 1'b0;

        // Reset held with clock running, then released: everything stays quiet.
        cyc(3);
        chk_idle32("rst_hold");
        chk("rst_hold_valid8", 128'(if8.vec_valid), 128'h0);
        chk("rst_hold_busy8",  128'(if8.busy),      128'h0);
        rst_n = 1'b1;
        cyc(2);
        chk_idle32("rst_release");
        if32.vec_ready = 1'b1;
        if8.vec_ready  = 1'b1;

        // Random mode, seed 1: full vector 0, lane 0 of vectors 1 and 2.
        push32(0, {32'hDAA66D2A, 32'h3C6EF373, 32'h9E3779B8, 32'h00000001}, M_ALL);
        push32(1, 128'h80200003, M_L0);
        push32(2, 128'hC0300002, M_L0);
        start32(2'd0, 32'h00000001, 3);
        chk("rand_t1_valid", 128'(if32.vec_valid), 128'h1);
        chk("rand_t1_busy",  128'(if32.busy),      128'h1);
        cyc(3);
        chk("rand_t4_done",  128'(if32.done),      128'h1);
        chk("rand_t4_valid", 128'(if32.vec_valid), 128'h0);
        chk("rand_t4_busy",  128'(if32.busy),      128'h0);
        cyc(1);
        chk("rand_t5_done",  128'(if32.done),      128'h0);

        // Count mode with a two-cycle stall at idx 1.
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 4; c++) d32[c*32 +: 32] = 32'(i + c);
            push32(i, d32, M_ALL);
        end
        hbase = hs32;
        start32(2'd1, 32'h0, 4);
        cyc(1);
        if32.vec_ready = 1'b0;
        chk("cnt_stall_idx", 128'(if32.vec_idx), 128'd1);
        for (int s = 0; s < 2; s++) begin
            cyc(1);
            chk("cnt_stall_data", if32.vec_data, {32'd4, 32'd3, 32'd2, 32'd1});
            chk("cnt_stall_idx_hold", 128'(if32.vec_idx), 128'd1);
        end
        if32.vec_ready = 1'b1;
        wait_done32(20);
        chk("cnt_handshakes", 128'(hs32 - hbase), 128'd4);

        // Zero-length job: done the cycle after start, no vector.
        start32(2'd1, 32'h0, 0);
        chk("zero_done",  128'(if32.done),      128'h1);
        chk("zero_valid", 128'(if32.vec_valid), 128'h0);
        chk("zero_busy",  128'(if32.busy),      128'h0);
        cyc(1);
        chk("zero_done_clear", 128'(if32.done), 128'h0);

        // Start while busy is ignored: still 5 count vectors, one done.
        for (int i = 0; i < 5; i++) begin
            for (int c = 0; c < 4; c++) d32[c*32 +: 32] = 32'(i + c);
            push32(i, d32, M_ALL);
        end
        hbase = hs32;
        dbase = done32;
        start32(2'd1, 32'h0, 5);
        cyc(1);
        start32(2'd3, 32'hAAAA5555, 2);
        wait_done32(20);
        cyc(2);
        chk("busy_start_handshakes", 128'(hs32 - hbase),   128'd5);
        chk("busy_start_dones",      128'(done32 - dbase), 128'd1);

        // Walking-one with 8-bit lanes: position wraps modulo 8.
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < 4; c++) d8[c*8 +: 8] = 8'(1) << ((i + c) % 8);
            push8(i, d8);
        end
        dbase = done8;
        if8.mode = 2'd2; if8.seed = 32'h0; if8.num_vec = 16'd10; if8.start = 1'b1;
        cyc(1);
        if8.start = 1'b0;
        wait_done8(30);
        cyc(1);
        chk("walk_handshakes", 128'(hs8),           128'd10);
        chk("walk_dones",      128'(done8 - dbase), 128'd1);

        // Reset at idx 2 of a random run, then replay the same seed.
        push32(0, {64'h0, 32'h8C032FC1, 32'h12345678}, M_L01);
        push32(1, {64'h0, 32'hC62197E3, 32'h091A2B3C}, M_L01);
        dbase = done32;
        start32(2'd0, 32'h12345678, 5);
        k = 0;
        while (if32.vec_idx != 16'd2 && k < 10) begin
            cyc(1);
            k++;
        end
        chk("midrst_reach_idx2", 128'(if32.vec_idx), 128'd2);
        rst_n = 1'b0;
        #1;
        chk_idle32("midrst");
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("midrst_no_done", 128'(done32 - dbase), 128'd0);

        push32(0, {64'h0, 32'h8C032FC1, 32'h12345678}, M_L01);
        push32(1, {64'h0, 32'hC62197E3, 32'h091A2B3C}, M_L01);
        start32(2'd0, 32'h12345678, 2);
        wait_done32(10);
        cyc(2);

        chk("q32_drained", 128'(q32.size()), 128'd0);
        chk("q8_drained",  128'(q8.size()),  128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stim_vector_gen.md
# stim_vector_gen

Parametrised multi-channel stimulus generator for the port-level testbench flow. It produces a sequence of `num_vec` input vectors. Each vector has `NUM_CH` lanes of `DATA_W` bits, and the lanes can be pseudo-random, counting, walking-one or constant. Vectors are delivered through a valid/ready handshake. The block replaces hand-written fixed literals with a seedable, replayable vector stream that drives a device under test (DUT) one vector per accepted handshake.

## Interface
Parameters:
- `NUM_CH`, 4: number of output lanes (1..16).
- `DATA_W`, 32: lane width (1..32).
- `CNT_W`, 16: width of the vector counter and index.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset; 0 resets the block.
- `start`  in  1: one-cycle request to begin a run; honoured only in IDLE.
- `mode`  in  2: 0 random, 1 count, 2 walking-one, 3 constant; sampled on accepted `start`.
- `seed`  in  32: base seed; sampled on accepted `start`.
- `num_vec`  in  CNT_W: number of vectors to emit; sampled on accepted `start`.
- `vec_data`  out  NUM_CH*DATA_W: lane c occupies bits [c*DATA_W +: DATA_W].
- `vec_valid`  out  1: `vec_data` and `vec_idx` are valid.
- `vec_ready`  in  1: consumer accepts the vector this cycle.
- `vec_idx`  out  CNT_W: index of the current vector, starting at 0.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse at run completion.

## Operation
- FSM states are IDLE and RUN.
  - IDLE → RUN on `start`.
  - RUN → IDLE after the last handshake.
- On accepted `start`, each channel register is seeded as follows:
  - Channel c gets `seed ^ (c*32'h9E3779B9)`, truncated to 32 bits.
  - A seed that evaluates to 0 is replaced by 32'h00000001, to avoid LFSR lockup.
- Random mode:
  - Each channel is a 32-bit Galois LFSR with mask 32'h80200003.
  - Step: lsb = r[0]; r = r>>1; if lsb, r ^= mask.
  - Lane c = r_c[DATA_W-1:0].
  - The LFSR advances only on a handshake (`vec_valid && vec_ready`).
- Count mode: lane c = (idx + c) mod 2^DATA_W.
- Walking-one mode: lane c = 1 << ((idx + c) mod DATA_W).
- Constant mode: every lane = `seed[DATA_W-1:0]`.
- `num_vec` = 0: no vector is emitted, and `done` pulses the cycle after `start`.
- `start` while `busy` is ignored. Mode, seed and count are not resampled.
- Backpressure: while `vec_valid && !vec_ready`, `vec_data` and `vec_idx` hold stable and the LFSRs hold.

## Timing
- Reset values: `vec_data` 0, `vec_valid` 0, `vec_idx` 0, `busy` 0, `done` 0, FSM in IDLE. All LFSRs hold 32'h00000001.
- Start latency: with `start` high at cycle T, `busy` and `vec_valid` are high at T+1, carrying vector 0.
- Throughput is one vector per cycle with `vec_ready` held high, with no bubbles.
- All outputs are registered.
- On the last handshake at cycle L (idx = `num_vec`-1):
  - `vec_valid` and `busy` are low at L+1.
  - `done` is high at L+1 only.
  - The FSM is in IDLE at L+1.
  - A new `start` is accepted at L+1.
- `vec_idx` increments on each handshake. Completion is detected by comparing against the sampled count, so `num_vec` = 2^CNT_W-1 completes without wrap.
- Reset asserted mid-run: all outputs clear immediately (asynchronously), no `done` pulse is produced, and the partial run is discarded.

## Structure
- Package `stim_pkg` holds:
  - the mode enum `stim_mode_e` (STIM_RAND, STIM_COUNT, STIM_WALK, STIM_CONST);
  - the constants `LFSR_MASK` = 32'h80200003 and `SEED_GOLDEN` = 32'h9E3779B9;
  - the function `lfsr_next(logic [31:0])`.
- Sub-module `stim_lfsr32` provides seed load, step enable and asynchronous active-low reset. It is instantiated `NUM_CH` times in a generate loop.
- The top level holds the FSM, counter and lane mux.

## Test plan
- Reset check: hold `reset`=0 and toggle the clock → every output is 0 and `busy` is 0. Release `reset` → outputs are unchanged until `start`.
- Random mode: `seed`=1, `num_vec`=3, `vec_ready`=1, `start` at T.
  - Lane 0 is 32'h00000001, 32'h80200003, 32'hC0300002 at T+1..T+3.
  - `done` is high at T+4.
- Count mode with backpressure: `num_vec`=4, `vec_ready` low for 2 cycles while idx = 1.
  - Lane c shows idx+c.
  - `vec_data` is held at {4,3,2,1} during the stall.
  - There are exactly 4 handshakes.
- Walking-one wrap, built with `DATA_W`=8: `num_vec`=10.
  - Lane 0 at idx 8 = 8'h01.
  - Lane 3 at idx 5 = 8'h01.
  - Lane 2 at idx 9 = 8'h08.
- Zero-count run: `num_vec`=0 → `done` at T+1 and `vec_valid` never high. A `start` issued mid-run of a 5-vector job is ignored, giving 5 handshakes and a single `done`.
- Reset mid-run: assert `reset` at idx 2 of a random run.
  - Outputs are 0 at once and no `done` is seen.
  - A restart with the same seed reproduces an identical vector 0 and vector 1.
